clkdist_pwr_seq: RTL and testbench

CLKDIST_PWR_SEQ -- requirements
Module: clkdist_pwr_seq

---
 rtl/clkdist_pwr_seq.sv | 170 +++++++++++++++++
 tb/tb_clkdist_pwr_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdist_pwr_seq.sv
// Power-up / self-test sequencer for the analog clock distribution block.
// Drives pdb and the ATB testbus select, and latches supply or self-test faults.
module clkdist_pwr_seq #(
  parameter int SETTLE_CYC = 16,
  parameter int WARM_CYC   = 8,
  parameter int DWELL_CYC  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       supply_ok,
  input  logic       atb_ok,
  input  logic       fault_clr,
  output logic       pdb,
  output logic [1:0] atb_ena,
  output logic       ready,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fail_code,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_BIAS     = 3'd1,
    ST_WARM     = 3'd2,
    ST_ATB_SUP  = 3'd3,
    ST_ATB_IREF = 3'd4,
    ST_RUN      = 3'd5,
    ST_STOP     = 3'd6,
    ST_FAULT    = 3'd7
  } state_t;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] WARM_LD   = 8'(WARM_CYC - 1);
  localparam logic [7:0] DWELL_LD  = 8'(DWELL_CYC - 1);
  localparam logic [7:0] STOP_LD   = 8'd1;

  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_SUP    = 2'b01;
  localparam logic [1:0] FC_IREF   = 2'b10;
  localparam logic [1:0] FC_SUPLOSS = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] fail_d;
  logic       last;

  logic       pdb_d, ready_d, busy_d, fault_d;
  logic [1:0] atb_d;

  assign last      = (cnt_q == 8'd0);
  assign dbg_state = state_q;

  // Next-state selection; the if/else chain order encodes the edge priority:
  // supply loss, then self-test fail, then en=0, then the normal advance.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_code;
    unique case (state_q)
      ST_OFF: begin
        if (en && supply_ok) state_d = ST_BIAS;
      end
      ST_FAULT: begin
        if (fault_clr && !en) begin
          state_d = ST_OFF;
          fail_d  = FC_NONE;
        end
      end
      default: begin
        if (!supply_ok) begin
          state_d = ST_FAULT;
          fail_d  = FC_SUPLOSS;
        end else if (state_q == ST_ATB_SUP && last && !atb_ok) begin
          state_d = ST_FAULT;
          fail_d  = FC_SUP;
        end else if (state_q == ST_ATB_IREF && last && !atb_ok) begin
          state_d = ST_FAULT;
          fail_d  = FC_IREF;
        end else if (!en && state_q != ST_STOP) begin
          state_d = ST_STOP;
        end else if (last) begin
          case (state_q)
            ST_BIAS:     state_d = ST_WARM;
            ST_WARM:     state_d = ST_ATB_SUP;
            ST_ATB_SUP:  state_d = ST_ATB_IREF;
            ST_ATB_IREF: state_d = ST_RUN;
            ST_STOP:     state_d = ST_OFF;
            default:     state_d = state_q;
          endcase
        end
      end
    endcase
  end

  // Load N-1 on entry to a timed state, otherwise count down and park at 0.
  always_comb begin
    cnt_d = last ? cnt_q : (cnt_q - 8'd1);
    if (state_d != state_q) begin
      case (state_d)
        ST_BIAS:     cnt_d = SETTLE_LD;
        ST_WARM:     cnt_d = WARM_LD;
        ST_ATB_SUP:  cnt_d = DWELL_LD;
        ST_ATB_IREF: cnt_d = DWELL_LD;
        ST_STOP:     cnt_d = STOP_LD;
        default:     cnt_d = 8'd0;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies
  // line up with the state register.
  always_comb begin
    pdb_d   = 1'b0;
    atb_d   = 2'b00;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      ST_BIAS: busy_d = 1'b1;
      ST_WARM: begin
        pdb_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_ATB_SUP: begin
        pdb_d  = 1'b1;
        atb_d  = 2'b01;
        busy_d = 1'b1;
      end
      ST_ATB_IREF: begin
        pdb_d  = 1'b1;
        atb_d  = 2'b11;
        busy_d = 1'b1;
      end
      ST_RUN: begin
        pdb_d   = 1'b1;
        ready_d = 1'b1;
      end
      ST_STOP: begin
        pdb_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      cnt_q     <= 8'd0;
      fail_code <= FC_NONE;
      pdb       <= 1'b0;
      atb_ena   <= 2'b00;
      ready     <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fail_code <= fail_d;
      pdb       <= pdb_d;
      atb_ena   <= atb_d;
      ready     <= ready_d;
      busy      <= busy_d;
      fault     <= fault_d;
    end
  end

endmodule

// File: tb/tb_clkdist_pwr_seq.sv
// Directed bench for clkdist_pwr_seq: default-parameter instance plus a
// 1-cycle-timing instance. Output vectors are {pdb, atb_ena, ready, busy, fault, fail_code}.
module tb_clkdist_pwr_seq;

  localparam logic [7:0] O_OFF   = 8'b0_00_0_0_0_00;
  localparam logic [7:0] O_BIAS  = 8'b0_00_0_1_0_00;
  localparam logic [7:0] O_WARM  = 8'b1_00_0_1_0_00;
  localparam logic [7:0] O_SUP   = 8'b1_01_0_1_0_00;
  localparam logic [7:0] O_IREF  = 8'b1_11_0_1_0_00;
  localparam logic [7:0] O_RUN   = 8'b1_00_1_0_0_00;
  localparam logic [7:0] O_STOP  = 8'b1_00_0_1_0_00;
  localparam logic [7:0] O_F01   = 8'b0_00_0_0_1_01;
  localparam logic [7:0] O_F10   = 8'b0_00_0_0_1_10;
  localparam logic [7:0] O_F11   = 8'b0_00_0_0_1_11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       en2 = 1'b0;
  logic       supply_ok = 1'b0;
  logic       atb_ok = 1'b0;
  logic       fault_clr = 1'b0;

  logic       pdb, ready, busy, fault;
  logic [1:0] atb_ena, fail_code;
  logic [2:0] dbg_state;
  logic       f_pdb, f_ready, f_busy, f_fault;
  logic [1:0] f_atb_ena, f_fail_code;
  logic [2:0] f_dbg_state;

  int total = 0;
  int bad = 0;

  clkdist_pwr_seq u_dut (
    .clk(clk), .rst(rst), .en(en), .supply_ok(supply_ok), .atb_ok(atb_ok),
    .fault_clr(fault_clr), .pdb(pdb), .atb_ena(atb_ena), .ready(ready),
    .busy(busy), .fault(fault), .fail_code(fail_code), .dbg_state(dbg_state)
  );

  clkdist_pwr_seq #(.SETTLE_CYC(1), .WARM_CYC(1), .DWELL_CYC(1)) u_fast (
    .clk(clk), .rst(rst), .en(en2), .supply_ok(supply_ok), .atb_ok(atb_ok),
    .fault_clr(fault_clr), .pdb(f_pdb), .atb_ena(f_atb_ena), .ready(f_ready),
    .busy(f_busy), .fault(f_fault), .fail_code(f_fail_code), .dbg_state(f_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {pdb, atb_ena, ready, busy, fault, fail_code};
  endfunction

  function automatic logic [7:0] outs_f();
    return {f_pdb, f_atb_ena, f_ready, f_busy, f_fault, f_fail_code};
  endfunction

  // One rising edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; en2 = 1'b0; supply_ok = 1'b1; atb_ok = 1'b1;
    step(); step();
    total++;
    if (outs() !== O_OFF) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), O_OFF); end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    total++;
    if (outs_f() !== O_OFF) begin bad++; $display("FAIL reset_fast_outs got=%b exp=%b", outs_f(), O_OFF); end
  endtask

  task automatic test_off_no_supply();
    rst = 1'b0; en = 1'b1; supply_ok = 1'b0;
    repeat (3) step();
    total++;
    if (outs() !== O_OFF) begin bad++; $display("FAIL off_no_supply got=%b exp=%b", outs(), O_OFF); end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL off_no_supply_state got=%0d exp=0", dbg_state); end
    en = 1'b0; supply_ok = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    en = 1'b1; supply_ok = 1'b1; atb_ok = 1'b1;
    step();  // edge k
    total++;
    if (outs() !== O_BIAS) begin bad++; $display("FAIL nom_k got=%b exp=%b", outs(), O_BIAS); end
    repeat (15) step();
    total++;
    if (outs() !== O_BIAS) begin bad++; $display("FAIL nom_k15 got=%b exp=%b", outs(), O_BIAS); end
    step();
    total++;
    if (outs() !== O_WARM) begin bad++; $display("FAIL nom_k16 got=%b exp=%b", outs(), O_WARM); end
    repeat (7) step();
    total++;
    if (outs() !== O_WARM) begin bad++; $display("FAIL nom_k23 got=%b exp=%b", outs(), O_WARM); end
    step();
    total++;
    if (outs() !== O_SUP) begin bad++; $display("FAIL nom_k24 got=%b exp=%b", outs(), O_SUP); end
    // atb_ok low before the last dwell cycle must be ignored
    atb_ok = 1'b0;
    repeat (3) step();
    total++;
    if (outs() !== O_SUP) begin bad++; $display("FAIL nom_k27_ignore got=%b exp=%b", outs(), O_SUP); end
    atb_ok = 1'b1;
    step();
    total++;
    if (outs() !== O_IREF) begin bad++; $display("FAIL nom_k28 got=%b exp=%b", outs(), O_IREF); end
    repeat (3) step();
    total++;
    if (outs() !== O_IREF) begin bad++; $display("FAIL nom_k31 got=%b exp=%b", outs(), O_IREF); end
    step();
    total++;
    if (outs() !== O_RUN) begin bad++; $display("FAIL nom_k32 got=%b exp=%b", outs(), O_RUN); end
  endtask

  task automatic test_power_down();
    en = 1'b0;
    step();
    total++;
    if (outs() !== O_STOP) begin bad++; $display("FAIL pd_stop1 got=%b exp=%b", outs(), O_STOP); end
    en = 1'b1;  // ignored during STOP
    step();
    total++;
    if (outs() !== O_STOP) begin bad++; $display("FAIL pd_stop2 got=%b exp=%b", outs(), O_STOP); end
    step();
    total++;
    if (outs() !== O_OFF) begin bad++; $display("FAIL pd_off got=%b exp=%b", outs(), O_OFF); end
    step();
    total++;
    if (outs() !== O_BIAS) begin bad++; $display("FAIL pd_restart got=%b exp=%b", outs(), O_BIAS); end
    repeat (16) step();
    total++;
    if (outs() !== O_WARM) begin bad++; $display("FAIL pd_warm got=%b exp=%b", outs(), O_WARM); end
    en = 1'b0;
    step();
    total++;
    if (dbg_state !== 3'd6) begin bad++; $display("FAIL pd_warm_stop_state got=%0d exp=6", dbg_state); end
    repeat (2) step();
    total++;
    if (outs() !== O_OFF) begin bad++; $display("FAIL pd_warm_off got=%b exp=%b", outs(), O_OFF); end
  endtask

  task automatic test_supply_test_fail();
    en = 1'b1; atb_ok = 1'b1;
    step();  // edge k
    repeat (27) step();
    total++;
    if (outs() !== O_SUP) begin bad++; $display("FAIL stf_k27 got=%b exp=%b", outs(), O_SUP); end
    atb_ok = 1'b0;
    step();
    total++;
    if (outs() !== O_F01) begin bad++; $display("FAIL stf_fault got=%b exp=%b", outs(), O_F01); end
    atb_ok = 1'b1; fault_clr = 1'b1;
    step();
    total++;
    if (outs() !== O_F01) begin bad++; $display("FAIL stf_clr_en1 got=%b exp=%b", outs(), O_F01); end
    en = 1'b0;
    step();
    total++;
    if (outs() !== O_OFF) begin bad++; $display("FAIL stf_clr_off got=%b exp=%b", outs(), O_OFF); end
    fault_clr = 1'b0;
  endtask

  task automatic test_iref_fail();
    en = 1'b1; atb_ok = 1'b1; fault_clr = 1'b1;  // no effect outside FAULT
    step();
    total++;
    if (outs() !== O_BIAS) begin bad++; $display("FAIL if_clr_outside got=%b exp=%b", outs(), O_BIAS); end
    fault_clr = 1'b0;
    repeat (31) step();
    total++;
    if (outs() !== O_IREF) begin bad++; $display("FAIL if_k31 got=%b exp=%b", outs(), O_IREF); end
    atb_ok = 1'b0;
    step();
    total++;
    if (outs() !== O_F10) begin bad++; $display("FAIL if_fault got=%b exp=%b", outs(), O_F10); end
    atb_ok = 1'b1; en = 1'b0; fault_clr = 1'b1;
    step();
    total++;
    if (outs() !== O_OFF) begin bad++; $display("FAIL if_clr_off got=%b exp=%b", outs(), O_OFF); end
    fault_clr = 1'b0;
  endtask

  task automatic test_supply_loss();
    en = 1'b1; atb_ok = 1'b1; supply_ok = 1'b1;
    step();
    repeat (32) step();
    total++;
    if (outs() !== O_RUN) begin bad++; $display("FAIL sl_run got=%b exp=%b", outs(), O_RUN); end
    supply_ok = 1'b0; en = 1'b0;  // supply loss outranks en=0
    step();
    total++;
    if (outs() !== O_F11) begin bad++; $display("FAIL sl_fault got=%b exp=%b", outs(), O_F11); end
    step();
    total++;
    if (outs() !== O_F11) begin bad++; $display("FAIL sl_hold got=%b exp=%b", outs(), O_F11); end
    supply_ok = 1'b1; fault_clr = 1'b1;
    step();
    total++;
    if (outs() !== O_OFF) begin bad++; $display("FAIL sl_clr got=%b exp=%b", outs(), O_OFF); end
    fault_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    en = 1'b1; atb_ok = 1'b1;
    step();
    repeat (28) step();
    total++;
    if (outs() !== O_IREF) begin bad++; $display("FAIL rm_iref got=%b exp=%b", outs(), O_IREF); end
    rst = 1'b1;
    step();
    total++;
    if (outs() !== O_OFF) begin bad++; $display("FAIL rm_reset got=%b exp=%b", outs(), O_OFF); end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL rm_reset_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
    step();
    total++;
    if (outs() !== O_BIAS) begin bad++; $display("FAIL rm_rebias got=%b exp=%b", outs(), O_BIAS); end
    en = 1'b0;
    repeat (3) step();
    total++;
    if (outs() !== O_OFF) begin bad++; $display("FAIL rm_off got=%b exp=%b", outs(), O_OFF); end
  endtask

  task automatic test_param_edge();
    supply_ok = 1'b1; atb_ok = 1'b1; en2 = 1'b1;
    step();
    total++;
    if (outs_f() !== O_BIAS) begin bad++; $display("FAIL pe_bias got=%b exp=%b", outs_f(), O_BIAS); end
    step();
    total++;
    if (outs_f() !== O_WARM) begin bad++; $display("FAIL pe_warm got=%b exp=%b", outs_f(), O_WARM); end
    step();
    total++;
    if (outs_f() !== O_SUP) begin bad++; $display("FAIL pe_sup got=%b exp=%b", outs_f(), O_SUP); end
    step();
    total++;
    if (outs_f() !== O_IREF) begin bad++; $display("FAIL pe_iref got=%b exp=%b", outs_f(), O_IREF); end
    step();
    total++;
    if (outs_f() !== O_RUN) begin bad++; $display("FAIL pe_run got=%b exp=%b", outs_f(), O_RUN); end
    en2 = 1'b0;
    repeat (3) step();
    total++;
    if (outs_f() !== O_OFF) begin bad++; $display("FAIL pe_off got=%b exp=%b", outs_f(), O_OFF); end
  endtask

  initial begin
    test_reset();
    test_off_no_supply();
    test_nominal();
    test_power_down();
    test_supply_test_fail();
    test_iref_fail();
    test_supply_loss();
    test_reset_mid();
    test_param_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
